// File: rtl/i2s_pkg.sv
// Shared I2S audio-path definitions: sample width, frame length and feeder FSM states.
package i2s_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int FRAME_CLKS = 64;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} feeder_state_t;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with combinational head read; pointers carry an extra wrap bit.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Storage has no reset; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/i2s_sample_feeder.sv
// Buffers stereo sample pairs and hands one pair per frame to the I2S transmitter,
// counting frames where the buffer had nothing to give.
module i2s_sample_feeder
  import i2s_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int FRAME_DIV   = FRAME_CLKS,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SAMPLE_W-1:0]    in_left,
  input  logic [SAMPLE_W-1:0]    in_right,
  output logic [SAMPLE_W-1:0]    sample_left,
  output logic [SAMPLE_W-1:0]    sample_right,
  output logic                   send,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   running,
  output logic [7:0]             underrun_cnt
);
  localparam int FW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(FRAME_DIV);

  feeder_state_t             state;
  logic [CW-1:0]             frame_cnt;
  logic                      tick_d;
  logic                      tick;
  logic                      push;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic [2*SAMPLE_W-1:0]     head;

  // Full comes straight from the pointer registers, so a same-cycle pop never frees a slot.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign tick     = (state == RUN) && enable && (frame_cnt == CW'(FRAME_DIV - 1));
  assign pop      = tick && !empty;
  assign running  = (state == RUN);

  sample_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({in_left, in_right}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      tick_d       <= 1'b0;
      send         <= 1'b0;
      sample_left  <= '0;
      sample_right <= '0;
      underrun_cnt <= '0;
    end else begin
      // Samples land on the tick edge; the strobe follows one cycle later.
      tick_d <= tick;
      send   <= tick_d;

      case (state)
        IDLE: begin
          frame_cnt <= '0;
          if (enable) state <= PRIME;
        end
        PRIME: begin
          frame_cnt <= '0;
          if (!enable) state <= IDLE;
          else if (fill >= FW'(PRIME_LEVEL)) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state     <= IDLE;
            frame_cnt <= '0;
          end else begin
            frame_cnt <= tick ? '0 : frame_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          frame_cnt <= '0;
        end
      endcase

      if (tick) begin
        if (!empty) begin
          sample_left  <= head[2*SAMPLE_W-1:SAMPLE_W];
          sample_right <= head[SAMPLE_W-1:0];
        end else begin
          sample_left  <= '0;
          sample_right <= '0;
          if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Scoreboard bench for i2s_sample_feeder: accepted pushes queue up, each send pops an expectation.
module tb_i2s_sample_feeder;
  localparam int FD = 64;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        send;
  logic [3:0]  fill;
  logic        running;
  logic [7:0]  underrun_cnt;

  i2s_sample_feeder #(.DEPTH(8), .FRAME_DIV(FD), .PRIME_LEVEL(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_left      (in_left),
    .in_right     (in_right),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .send         (send),
    .fill         (fill),
    .running      (running),
    .underrun_cnt (underrun_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int send_count = 0;
  int send_cyc   = 0;
  int run_cyc    = 0;

  logic [31:0] q[$];
  logic        d1_v, d2_v;
  logic [31:0] d1_d, d2_d;
  logic [15:0] exp_left, exp_right;
  int          exp_under;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: a push seen before edge m+1 is only visible to a tick two edges later or beyond.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      q.delete();
      d1_v = 1'b0; d2_v = 1'b0;
      exp_left = '0; exp_right = '0; exp_under = 0;
    end else begin
      if (send) begin
        logic [31:0] p;
        send_count++;
        send_cyc = cyc;
        if (q.size() > 0) begin
          p = q.pop_front();
          exp_left  = p[31:16];
          exp_right = p[15:0];
        end else begin
          exp_left  = '0;
          exp_right = '0;
          if (exp_under != 255) exp_under++;
        end
        $display("send #%0d cyc=%0d left=%h right=%h underruns=%0d",
                 send_count, cyc, sample_left, sample_right, underrun_cnt);
        check("send_left", 32'(sample_left), 32'(exp_left));
        check("send_right", 32'(sample_right), 32'(exp_right));
        check("send_underrun", 32'(underrun_cnt), 32'(exp_under));
      end
      if (d2_v) q.push_back(d2_d);
      d2_v = d1_v;
      d2_d = d1_d;
      d1_v = in_valid && in_ready;
      d1_d = {in_left, in_right};
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    in_left = l; in_right = r; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_sends(input int n);
    int target;
    target = send_count + n;
    for (int i = 0; i < n * FD + 200 && send_count < target; i++) step(1);
    check("send_timeout", 32'(send_count >= target), 32'd1);
  endtask

  task automatic wait_running();
    int i;
    for (i = 0; i < 50 && !running; i++) step(1);
    run_cyc = cyc;
    check("run_timeout", 32'(running), 32'd1);
  endtask

  // Present a pair so that it is clocked in on the next frame-tick edge.
  task automatic push_at_tick(input logic [15:0] l, input logic [15:0] r);
    for (int i = 0; i < 2 * FD && cyc != send_cyc + FD - 2; i++) step(1);
    check("tick_align", 32'(cyc), 32'(send_cyc + FD - 2));
    push(l, r);
  endtask

  initial begin
    int sends_before;
    int idx;
    logic rdy;

    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
    #23;
    reset = 1'b1;
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    step(2);
    reset = 1'b0;

    // Idle: nothing moves for 200 cycles.
    step(200);
    check("idle_sends", 32'(send_count), 32'd0);
    check("idle_outputs", {sample_left, sample_right}, 32'd0);
    check("idle_running", 32'(running), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_underrun", 32'(underrun_cnt), 32'd0);

    // Prime and stream, then run dry.
    push(16'h1111, 16'hAAAA);
    push(16'h2222, 16'hBBBB);
    push(16'h3333, 16'hCCCC);
    push(16'h4444, 16'hDDDD);
    check("prime_fill", 32'(fill), 32'd4);
    enable = 1'b1;
    wait_running();
    wait_sends(1);
    check("first_send_latency", 32'(send_cyc - run_cyc), 32'(FD + 1));
    sends_before = send_cyc;
    wait_sends(1);
    check("frame_period", 32'(send_cyc - sends_before), 32'(FD));
    wait_sends(4);
    check("underrun_two", 32'(underrun_cnt), 32'd2);
    check("underrun_running", 32'(running), 32'd1);
    push(16'h5555, 16'hEEEE);
    wait_sends(1);
    check("recover_underrun", 32'(underrun_cnt), 32'd2);

    // Push and pop on the same tick edge.
    for (int i = 0; i < 3; i++) push(16'h6000 + 16'(i), 16'hB000 + 16'(i));
    check("fill_three", 32'(fill), 32'd3);
    push_at_tick(16'h6003, 16'hB003);
    check("pushpop_fill", 32'(fill), 32'd3);
    wait_sends(4);
    check("drained_fill", 32'(fill), 32'd0);
    push_at_tick(16'h7000, 16'hC000);
    check("empty_tick_fill", 32'(fill), 32'd1);
    check("empty_tick_underrun", 32'(underrun_cnt), 32'd3);
    wait_sends(2);

    // Drop enable mid-frame.
    push(16'h8000, 16'hD000);
    for (int i = 0; i < 2 * FD && cyc != send_cyc + 28; i++) step(1);
    enable = 1'b0;
    sends_before = send_count;
    step(150);
    check("drop_no_send", 32'(send_count), 32'(sends_before));
    check("drop_hold", {sample_left, sample_right}, 32'h7000C000);
    check("drop_fill", 32'(fill), 32'd1);
    check("drop_running", 32'(running), 32'd0);
    enable = 1'b1;
    step(20);
    check("reprime_wait", 32'(running), 32'd0);
    enable = 1'b0;
    step(2);

    // Fill to capacity while idle, keep one pair waiting.
    idx = 0;
    in_left = 16'h9000; in_right = 16'hE000; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rdy = in_ready;
      step(1);
      if (rdy) begin
        idx++;
        in_left = 16'h9000 + 16'(idx); in_right = 16'hE000 + 16'(idx);
      end
    end
    check("full_fill", 32'(fill), 32'd8);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_accepted", 32'(idx), 32'd7);
    enable = 1'b1;
    wait_sends(1);
    check("refill_fill", 32'(fill), 32'd8);
    check("refill_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_sends(2);

    // Reset in the middle of a run.
    step(10);
    #3;
    reset = 1'b1;
    enable = 1'b0;
    #1;
    check("midrst_fill", 32'(fill), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_samples", {sample_left, sample_right}, 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_underrun", 32'(underrun_cnt), 32'd0);
    check("midrst_send", 32'(send), 32'd0);
    step(2);
    reset = 1'b0;
    step(5);
    check("post_rst_fill", 32'(fill), 32'd0);
    check("post_rst_running", 32'(running), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=%0d exp=<finish>", cyc);
    $fatal(1, "timeout");
  end
endmodule
